// File: rtl/fixed_to_float_enc.sv
// Iterative fixed-point to mantissa/exponent encoder: arithmetic-shifts the input right one
// bit per cycle until it fits the signed mantissa, tracking the shift count and lost bits.
module fixed_to_float_enc #(
    parameter int MAN_W = 4,
    parameter int EXP_W = 3,
    parameter int IN_W  = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [MAN_W-1:0] mantissa,
    output logic signed [EXP_W-1:0] exp,
    output logic                    inexact
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [EXP_W-1:0] EXP_BIAS = {1'b1, {(EXP_W-1){1'b0}}};

    state_t                  state;
    state_t                  state_nx;
    logic signed [IN_W-1:0]  sh;
    logic        [EXP_W-1:0] k;
    logic                    sticky;
    logic                    fit;

    // Value fits the mantissa when every bit from the top down to the mantissa sign bit agrees.
    function automatic logic fits_mantissa(input logic signed [IN_W-1:0] x);
        logic [IN_W-MAN_W:0] top;
        top = x[IN_W-1:MAN_W-1];
        return (&top) | ~(|top);
    endfunction

    function automatic logic signed [EXP_W-1:0] shift_to_exp(input logic [EXP_W-1:0] cnt);
        return signed'(cnt - EXP_BIAS);
    endfunction

    assign fit       = fits_mantissa(sh);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = CALC;
            CALC:    if (fit)       state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sh       <= '0;
            k        <= '0;
            sticky   <= 1'b0;
            mantissa <= '0;
            exp      <= '0;
            inexact  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh     <= in_data;
                        k      <= '0;
                        sticky <= 1'b0;
                    end
                end
                CALC: begin
                    if (fit) begin
                        mantissa <= sh[MAN_W-1:0];
                        exp      <= shift_to_exp(k);
                        inexact  <= sticky;
                    end else begin
                        // k cannot wrap: after 2^EXP_W-1 shifts any input fits.
                        sh     <= sh >>> 1;
                        sticky <= sticky | sh[0];
                        k      <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_float_enc.sv
// Bench for fixed_to_float_enc: directed vectors with literal expectations plus a
// cycle-level reference model compared on every falling edge.
module tb_fixed_to_float_enc;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [10:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [3:0]  mantissa;
    logic signed [2:0]  exp;
    logic               inexact;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fixed_to_float_enc dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mantissa (mantissa),
        .exp      (exp),
        .inexact  (inexact)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Encoding straight from its definition: smallest k with v/2^k (floor) in [-8,7].
    function automatic void enc(input int v, output int k, output int m, output int e,
                                output int x);
        k = 0;
        m = v;
        while (m < -8 || m > 7) begin
            k++;
            m = v >>> k;
        end
        e = k - 4;
        x = (v != m * (1 << k)) ? 1 : 0;
    endfunction

    // Reference model: phase 0 idle, 1 busy for k+1 cycles, 2 holding a result.
    int phase = 0, cnt = 0, mm = 0, me = 0, mx = 0;
    int pk, pm, pe, px;

    always @(posedge clk) begin
        if (reset) begin
            phase = 0; cnt = 0; mm = 0; me = 0; mx = 0;
        end else begin
            case (phase)
                0: if (in_valid) begin
                    enc(int'(in_data), pk, pm, pe, px);
                    cnt   = pk + 1;
                    phase = 1;
                end
                1: begin
                    cnt--;
                    if (cnt == 0) begin
                        phase = 2; mm = pm; me = pe; mx = px;
                    end
                end
                default: if (out_ready) phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("model_in_ready",  in_ready,  (phase == 0) ? 1 : 0);
        chk("model_out_valid", out_valid, (phase == 2) ? 1 : 0);
        chk("model_mantissa",  mantissa,  mm);
        chk("model_exp",       exp,       me);
        chk("model_inexact",   inexact,   mx);
    end

    task automatic start(input logic [10:0] v);
        in_data  = v;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int lat, input int m, input int e, input int x);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("latency",  n, lat);
        chk("mantissa", mantissa, m);
        chk("exp",      exp, e);
        chk("inexact",  inexact, x);
    endtask

    task automatic send(input logic [10:0] v, input int lat, input int m, input int e,
                        input int x);
        start(v);
        wait_done(lat, m, e, x);
        @(posedge clk); #2;
        chk("ready_after_done", in_ready, 1);
    endtask

    int lk, lm, le, lx;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        chk("rst_in_ready",  in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mantissa",  mantissa, 0);
        chk("rst_exp",       exp, 0);
        chk("rst_inexact",   inexact, 0);

        // Pin the model against hand-computed encodings.
        enc(5, lk, lm, le, lx);
        chk("lit5_k", lk, 0); chk("lit5_m", lm, 5); chk("lit5_e", le, -4); chk("lit5_x", lx, 0);
        enc(48, lk, lm, le, lx);
        chk("lit48_k", lk, 3); chk("lit48_m", lm, 6); chk("lit48_x", lx, 0);
        chk("lit48_roundtrip", lm * (1 << (4 + le)), 48);
        enc(-1024, lk, lm, le, lx);
        chk("litm1024_m", lm, -8); chk("litm1024_e", le, 3); chk("litm1024_x", lx, 0);
        enc(1023, lk, lm, le, lx);
        chk("lit1023_m", lm, 7); chk("lit1023_e", le, 3); chk("lit1023_x", lx, 1);
        enc(-9, lk, lm, le, lx);
        chk("litm9_m", lm, -5); chk("litm9_e", le, -3); chk("litm9_x", lx, 1);
        chk("litm9_roundtrip", lm * (1 << (4 + le)), -10);
        enc(-8, lk, lm, le, lx);
        chk("litm8_k", lk, 0); chk("litm8_m", lm, -8);

        send(11'h005, 1,  5, -4, 0);
        send(11'h030, 4,  6, -1, 0);
        send(11'h400, 8, -8,  3, 0);
        send(11'h3FF, 8,  7,  3, 1);
        send(11'h7F7, 2, -5, -3, 1);
        send(11'h7F8, 1, -8, -4, 0);

        // Backpressure: result held, second request during the stall ignored.
        out_ready = 1'b0;
        start(11'h030);
        wait_done(4, 6, -1, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                in_valid = 1'b1;
                in_data  = 11'h005;
            end
            @(posedge clk); #2;
            in_valid = 1'b0;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready",  in_ready, 0);
            chk("bp_mantissa",  mantissa, 6);
            chk("bp_exp",       exp, -1);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        send(11'h7F7, 2, -5, -3, 1);

        // Reset in the middle of a long conversion.
        start(11'h3FF);
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready",  in_ready, 1);
        chk("midrst_mantissa",  mantissa, 0);
        chk("midrst_exp",       exp, 0);
        chk("midrst_inexact",   inexact, 0);
        send(11'h005, 1, 5, -4, 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
